// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and width helpers for the set-associative
//               instruction cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  // Controller states: idle/lookup, or waiting for a line refill
  typedef enum logic [0:0] {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } icache_state_e;

  // Widest tag the per-way view can carry; real tags are zero-extended
  localparam int TAG_MAX_W = 64;

  // Per-way view of one line's bookkeeping
  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    logic                 valid;
  } line_meta_t;

  function automatic int offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - offset_w(line_w) - index_w(sets);
  endfunction

  // A single-way cache still carries a 1-bit pointer that is held at zero
  function automatic int ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_way_sel.sv
`default_nettype none
// ============================================================================
// Module      : icache_way_sel
// Description : Combinational hit detection and victim-way selection for
//               one cache set.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_way_sel #(
  parameter int WAYS  = 2,
  parameter int PTR_W = 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  match,
  input  logic [PTR_W-1:0] ptr,
  output logic [WAYS-1:0]  hit_vec,
  output logic [PTR_W-1:0] hit_way,
  output logic [PTR_W-1:0] victim_way,
  output logic             all_valid
);

  // Encode the hit vector and pick the lowest invalid way, else the pointer
  always_comb begin
    hit_vec    = valid & match;
    hit_way    = '0;
    all_valid  = &valid;
    victim_way = ptr;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_vec[i]) hit_way = PTR_W'(i);
    end
    if (!all_valid) begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (!valid[i]) victim_way = PTR_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_sa_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_sa_ctrl
// Description : N-way set-associative instruction cache with refill
//               controller, round-robin replacement and refill-safe flush.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_sa_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              if2ic_req_i,
  input  logic [ADDR_W-1:0] if2ic_addr_i,
  output logic              ic2if_ready_o,
  output logic              ic2if_valid_o,
  output logic [DATA_W-1:0] ic2if_data_o,
  output logic              ic2mem_req_o,
  output logic [ADDR_W-1:0] ic2mem_addr_o,
  input  logic              mem2ic_valid_i,
  input  logic [LINE_W-1:0] mem2ic_data_i
);

  localparam int OFF_W  = offset_w(LINE_W);
  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int PTR_W  = ptr_w(WAYS);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WORDS  = LINE_W / DATA_W;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (OFF_W + IDX_W));
  endfunction

  function automatic logic [WSEL_W-1:0] addr_wsel(input logic [ADDR_W-1:0] a);
    return WSEL_W'(a >> BYTE_W) & WSEL_W'(WORDS - 1);
  endfunction

  function automatic logic [DATA_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic [WSEL_W-1:0] sel);
    return DATA_W'(line >> (int'(sel) * DATA_W));
  endfunction

  icache_state_e state_q, state_d;
  logic [ADDR_W-1:0]           addr_q;
  logic                        discard_q;
  logic [SETS-1:0][WAYS-1:0]   valid_q;
  logic [SETS-1:0][PTR_W-1:0]  ptr_q;
  logic [TAG_W-1:0]            tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]           data_q [SETS][WAYS];

  line_meta_t       cur_meta [WAYS];
  logic [IDX_W-1:0] idx_lu;
  logic [WAYS-1:0]  valid_vec, match_vec, hit_vec;
  logic [PTR_W-1:0] hit_way, victim_way;
  logic             all_valid, hit, accept, hit_take, refill_done, install;

  wire [IDX_W-1:0]  req_idx  = addr_idx(if2ic_addr_i);
  wire [TAG_W-1:0]  req_tag  = addr_tag(if2ic_addr_i);
  wire [WSEL_W-1:0] req_wsel = addr_wsel(if2ic_addr_i);
  wire [IDX_W-1:0]  idx_q    = addr_idx(addr_q);
  wire [TAG_W-1:0]  ltag_q   = addr_tag(addr_q);
  wire [WSEL_W-1:0] wsel_q   = addr_wsel(addr_q);

  assign ic2if_ready_o = (state_q == IC_IDLE);
  assign ic2mem_req_o  = (state_q == IC_MISS);
  assign ic2mem_addr_o = addr_q & ~OFF_MASK;

  // While refilling, the set under inspection is the latched one (victim pick)
  assign idx_lu      = (state_q == IC_MISS) ? idx_q : req_idx;
  assign accept      = ic2if_ready_o && if2ic_req_i;
  assign hit         = $onehot(hit_vec);
  assign hit_take    = accept && hit && !flush_i;
  assign refill_done = (state_q == IC_MISS) && mem2ic_valid_i;
  assign install     = refill_done && !flush_i && !discard_q;

  // Assemble the per-way view of the set being looked up
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      cur_meta[w].tag   = TAG_MAX_W'(tag_q[idx_lu][w]);
      cur_meta[w].valid = valid_q[idx_lu][w];
      valid_vec[w]      = cur_meta[w].valid;
      match_vec[w]      = (cur_meta[w].tag == TAG_MAX_W'(req_tag));
    end
  end

  icache_way_sel #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_way_sel (
    .valid      (valid_vec),
    .match      (match_vec),
    .ptr        (ptr_q[idx_lu]),
    .hit_vec    (hit_vec),
    .hit_way    (hit_way),
    .victim_way (victim_way),
    .all_valid  (all_valid)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IC_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state: a flush coinciding with a request forces the miss path
  always_comb begin
    state_d = state_q;
    case (state_q)
      IC_IDLE: if (accept && !hit_take) state_d = IC_MISS;
      IC_MISS: if (mem2ic_valid_i)      state_d = IC_IDLE;
      default: state_d = IC_IDLE;
    endcase
  end

  // Latched request address and the refill-discard flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      if (accept) addr_q <= if2ic_addr_i;
      if (refill_done)                              discard_q <= 1'b0;
      else if (flush_i && (state_q == IC_MISS))     discard_q <= 1'b1;
    end
  end

  // Response register: hit word from the array or requested word of the refill
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic2if_valid_o <= 1'b0;
      ic2if_data_o  <= '0;
    end else begin
      ic2if_valid_o <= hit_take || refill_done;
      if (hit_take)         ic2if_data_o <= pick_word(data_q[req_idx][hit_way], req_wsel);
      else if (refill_done) ic2if_data_o <= pick_word(mem2ic_data_i, wsel_q);
    end
  end

  // Valid bits and round-robin pointers; flush wins over an install
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (install) begin
      valid_q[idx_q][victim_way] <= 1'b1;
      if (all_valid) ptr_q[idx_q] <= (WAYS == 1) ? '0 : ptr_q[idx_q] + 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk_i) begin
    if (install) begin
      tag_q[idx_q][victim_way]  <= ltag_q;
      data_q[idx_q][victim_way] <= mem2ic_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_sa_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_sa_ctrl
// Description : Directed self-checking bench for icache_sa_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_sa_ctrl;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush = 1'b0;
  logic         req = 1'b0;
  logic [31:0]  addr = '0;
  logic         ready, valid, mem_req;
  logic [31:0]  data, mem_addr;
  logic         mem_valid = 1'b0;
  logic [127:0] mem_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  icache_sa_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .LINE_W (128),
    .SETS   (64),
    .WAYS   (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush),
    .if2ic_req_i    (req),
    .if2ic_addr_i   (addr),
    .ic2if_ready_o  (ready),
    .ic2if_valid_o  (valid),
    .ic2if_data_o   (data),
    .ic2mem_req_o   (mem_req),
    .ic2mem_addr_o  (mem_addr),
    .mem2ic_valid_i (mem_valid),
    .mem2ic_data_i  (mem_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // At most one way of a set may ever match
  always @(negedge clk) begin
    if (rst_ni) begin
      assert ($onehot0(dut.hit_vec))
      else begin
        n_errors++;
        $display("FAIL multi_hit: hit_vec %b expected one-hot or zero", dut.hit_vec);
      end
    end
  end

  // Memory contents: one fixed line from the test plan, a pattern elsewhere
  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] ln;
    if (la == 32'h0000_1000) return 128'h00a0006f_04934429_08630640_44630094;
    for (int k = 0; k < 4; k++) ln[k*32 +: 32] = la ^ ((k + 1) * 32'h0101_0101) ^ 32'h5a5a_0000;
    return ln;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [127:0] ln;
    ln = mem_line(a & ~32'hF);
    return ln[a[3:2]*32 +: 32];
  endfunction

  // fmode: 0 plain, 1 flush together with the request, 2 flush during MISS
  task automatic do_fetch(input logic [31:0] a, input bit exp_hit, input int fmode, input string tag);
    logic [31:0] la;
    la = a & ~32'hF;
    @(negedge clk);
    check({tag, ":ready"}, {31'd0, ready}, 32'd1);
    req = 1'b1; addr = a; flush = (fmode == 1);
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    if (exp_hit) begin
      check({tag, ":hit_valid"}, {31'd0, valid}, 32'd1);
      check({tag, ":hit_data"}, data, exp_word(a));
      check({tag, ":hit_no_memreq"}, {31'd0, mem_req}, 32'd0);
    end else begin
      check({tag, ":miss_valid"}, {31'd0, valid}, 32'd0);
      check({tag, ":miss_memreq"}, {31'd0, mem_req}, 32'd1);
      check({tag, ":miss_memaddr"}, mem_addr, la);
      check({tag, ":miss_ready"}, {31'd0, ready}, 32'd0);
      for (int k = 0; k < 2; k++) begin
        flush = (fmode == 2 && k == 0);
        @(negedge clk);
        flush = 1'b0;
        check({tag, ":wait_memreq"}, {31'd0, mem_req}, 32'd1);
        check({tag, ":wait_memaddr"}, mem_addr, la);
      end
      mem_valid = 1'b1; mem_data = mem_line(la);
      @(negedge clk);
      mem_valid = 1'b0; mem_data = '0;
      check({tag, ":refill_valid"}, {31'd0, valid}, 32'd1);
      check({tag, ":refill_data"}, data, exp_word(a));
      check({tag, ":refill_memreq"}, {31'd0, mem_req}, 32'd0);
      check({tag, ":refill_ready"}, {31'd0, ready}, 32'd1);
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    // Reset values
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_memaddr", mem_addr, 32'd0);
    @(negedge clk); rst_ni = 1'b1;

    // Cold miss then hit
    do_fetch(32'h0000_1004, 1'b0, 0, "cold_miss");
    do_fetch(32'h0000_100C, 1'b1, 0, "cold_hit");

    // Back-to-back hits across the resident line
    prev = '0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_valid", {31'd0, valid}, 32'd1);
        check("b2b_data", data, prev);
      end
      if (i < 8) begin
        req = 1'b1; addr = 32'h0000_1000 + 32'((i % 4) * 4);
        prev = exp_word(addr);
      end else begin
        req = 1'b0;
      end
    end

    // Conflict and round-robin replacement in set 0
    do_fetch(32'h0000_2000, 1'b0, 0, "fill_2000");
    do_fetch(32'h0000_3000, 1'b0, 0, "evict_1000");
    do_fetch(32'h0000_2000, 1'b1, 0, "keep_2000");
    do_fetch(32'h0000_1000, 1'b0, 0, "remiss_1000");

    // Flush together with a request of a resident line forces a miss
    do_fetch(32'h0000_1000, 1'b0, 1, "flush_at_req");

    // Flush during MISS: word still delivered, line not installed
    pulse_flush();
    do_fetch(32'h0000_1000, 1'b0, 2, "flush_mid");
    do_fetch(32'h0000_1000, 1'b0, 0, "after_flush_mid");

    // Four resident lines, then flush
    do_fetch(32'h0000_1010, 1'b0, 0, "fill_1010");
    do_fetch(32'h0000_1020, 1'b0, 0, "fill_1020");
    do_fetch(32'h0000_1030, 1'b0, 0, "fill_1030");
    do_fetch(32'h0000_1034, 1'b1, 0, "hit_1034");
    pulse_flush();
    do_fetch(32'h0000_1000, 1'b0, 0, "postflush_1000");
    do_fetch(32'h0000_1010, 1'b0, 0, "postflush_1010");
    do_fetch(32'h0000_1020, 1'b0, 0, "postflush_1020");
    do_fetch(32'h0000_1030, 1'b0, 0, "postflush_1030");

    // Reset mid-miss, then a stray refill beat
    @(negedge clk); req = 1'b1; addr = 32'h0000_5000;
    @(negedge clk); req = 1'b0;
    check("rmm_memreq", {31'd0, mem_req}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rmm_ready", {31'd0, ready}, 32'd1);
    check("rmm_memreq_low", {31'd0, mem_req}, 32'd0);
    check("rmm_memaddr", mem_addr, 32'd0);
    check("rmm_valid", {31'd0, valid}, 32'd0);
    check("rmm_data", data, 32'd0);
    @(negedge clk); rst_ni = 1'b1;
    mem_valid = 1'b1; mem_data = mem_line(32'h0000_5000);
    @(negedge clk); mem_valid = 1'b0; mem_data = '0;
    check("stray_valid", {31'd0, valid}, 32'd0);
    check("stray_memreq", {31'd0, mem_req}, 32'd0);
    check("stray_ready", {31'd0, ready}, 32'd1);
    do_fetch(32'h0000_1000, 1'b0, 0, "postreset_miss");
    do_fetch(32'h0000_1008, 1'b1, 0, "postreset_hit");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
